// File: rtl/game_flow_controller.sv
// Screen sequencer for the wand-duel game: LOGO, SELECT, TUTORIAL, PLAY,
// LEADERBOARD, PLAY_AGAIN, with whole-second screen timers and mode latch.
module game_flow_controller #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int LOGO_SECS  = 3,
  parameter int TUT_SECS   = 30,
  parameter int GAME_SECS  = 60,
  parameter int LEAD_SECS  = 10,
  parameter int AGAIN_SECS = 10,
  parameter int SNITCH_AT  = 30,
  parameter int SNITCH_LEN = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       mode_sel_valid,
  input  logic       mode_two_player,
  input  logic       mode_learn,
  input  logic       end_game_early,
  input  logic       end_tutorial,
  input  logic       again_yes,
  input  logic       again_no,
  output logic [2:0] screen,
  output logic       logo,
  output logic       select_mode,
  output logic       learn_active,
  output logic       play_active,
  output logic       leaderboard,
  output logic       play_again,
  output logic       two_player_mode,
  output logic       selected_a_mode,
  output logic       snitch_powerup,
  output logic [7:0] seconds_left,
  output logic       end_of_game,
  output logic       score_clear
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam int SN_HI = GAME_SECS - SNITCH_AT;
  localparam int SN_LO = SN_HI - SNITCH_LEN;

  localparam logic [7:0] LOGO8  = 8'(LOGO_SECS);
  localparam logic [7:0] TUT8   = 8'(TUT_SECS);
  localparam logic [7:0] GAME8  = 8'(GAME_SECS);
  localparam logic [7:0] LEAD8  = 8'(LEAD_SECS);
  localparam logic [7:0] AGAIN8 = 8'(AGAIN_SECS);

  typedef enum logic [2:0] {
    S_LOGO   = 3'd0,
    S_SELECT = 3'd1,
    S_TUT    = 3'd2,
    S_PLAY   = 3'd3,
    S_LEAD   = 3'd4,
    S_AGAIN  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    secs_n;
  logic          tp_n, sel_n, eog_n, clr_n, snitch_n;
  logic          tick, expire;

  assign tick   = (presc == LAST);
  assign expire = tick && (seconds_left == 8'd1);
  assign screen = state;

  always_comb begin
    state_n = state;
    secs_n  = seconds_left;
    tp_n    = two_player_mode;
    sel_n   = 1'b0;
    eog_n   = 1'b0;
    clr_n   = 1'b0;
    unique case (state)
      S_LOGO: begin
        if (expire) begin
          state_n = S_SELECT;
          secs_n  = 8'd0;
        end
      end
      S_SELECT: begin
        if (mode_sel_valid) begin
          sel_n = 1'b1;
          if (mode_learn) begin
            state_n = S_TUT;
            tp_n    = 1'b0;
            secs_n  = TUT8;
          end else begin
            state_n = S_PLAY;
            tp_n    = mode_two_player;
            secs_n  = GAME8;
          end
        end
      end
      S_TUT: begin
        if (end_tutorial || expire) begin
          state_n = S_SELECT;
          secs_n  = 8'd0;
        end
      end
      S_PLAY: begin
        if (end_game_early || expire) begin
          state_n = S_LEAD;
          secs_n  = LEAD8;
          eog_n   = 1'b1;
        end
      end
      S_LEAD: begin
        if (expire) begin
          state_n = S_AGAIN;
          secs_n  = AGAIN8;
        end
      end
      S_AGAIN: begin
        if (again_yes) begin
          state_n = S_SELECT;
          secs_n  = 8'd0;
          clr_n   = 1'b1;
        end else if (again_no || expire) begin
          state_n = S_LOGO;
          secs_n  = LOGO8;
        end
      end
      default: begin
        state_n = S_LOGO;
        secs_n  = LOGO8;
      end
    endcase
    // SELECT holds 0 so the >1 guard also keeps it from counting
    if (state_n == state && tick && seconds_left > 8'd1)
      secs_n = seconds_left - 8'd1;
    presc_n = (state_n != state || tick) ? '0 : presc + 1'b1;
    snitch_n = (state_n == S_PLAY)
            && (int'(secs_n) <= SN_HI)
            && (int'(secs_n) > SN_LO);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= S_LOGO;
      presc           <= '0;
      seconds_left    <= LOGO8;
      two_player_mode <= 1'b0;
      selected_a_mode <= 1'b0;
      end_of_game     <= 1'b0;
      score_clear     <= 1'b0;
      snitch_powerup  <= 1'b0;
      logo            <= 1'b1;
      select_mode     <= 1'b0;
      learn_active    <= 1'b0;
      play_active     <= 1'b0;
      leaderboard     <= 1'b0;
      play_again      <= 1'b0;
    end else begin
      state           <= state_n;
      presc           <= presc_n;
      seconds_left    <= secs_n;
      two_player_mode <= tp_n;
      selected_a_mode <= sel_n;
      end_of_game     <= eog_n;
      score_clear     <= clr_n;
      snitch_powerup  <= snitch_n;
      logo            <= (state_n == S_LOGO);
      select_mode     <= (state_n == S_SELECT);
      learn_active    <= (state_n == S_TUT);
      play_active     <= (state_n == S_PLAY);
      leaderboard     <= (state_n == S_LEAD);
      play_again      <= (state_n == S_AGAIN);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed flow plus random pulses, checked
// every cycle against a screen/elapsed-cycle reference model.
module tb_game_flow_controller;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       mode_sel_valid, mode_two_player, mode_learn;
  logic       end_game_early, end_tutorial, again_yes, again_no;
  logic [2:0] screen;
  logic       logo, select_mode, learn_active, play_active;
  logic       leaderboard, play_again;
  logic       two_player_mode, selected_a_mode, snitch_powerup;
  logic [7:0] seconds_left;
  logic       end_of_game, score_clear;

  int compared = 0;
  int mismatched = 0;
  int snitch_seen = 0;
  int eog_seen = 0;

  // reference model: current screen and cycles spent on it
  int m_scr, m_cyc;
  bit m_tp, m_sel, m_eog, m_clr;

  game_flow_controller #(.TICK_DIV(TD)) dut (
    .clock(clock), .resetn(resetn),
    .mode_sel_valid(mode_sel_valid), .mode_two_player(mode_two_player),
    .mode_learn(mode_learn), .end_game_early(end_game_early),
    .end_tutorial(end_tutorial), .again_yes(again_yes), .again_no(again_no),
    .screen(screen), .logo(logo), .select_mode(select_mode),
    .learn_active(learn_active), .play_active(play_active),
    .leaderboard(leaderboard), .play_again(play_again),
    .two_player_mode(two_player_mode), .selected_a_mode(selected_a_mode),
    .snitch_powerup(snitch_powerup), .seconds_left(seconds_left),
    .end_of_game(end_of_game), .score_clear(score_clear)
  );

  always #5 clock = ~clock;

  function automatic int dur(input int s);
    case (s)
      0: return 3;
      2: return 30;
      3: return 60;
      4: return 10;
      5: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_secs();
    if (m_scr == 1) return 0;
    return dur(m_scr) - m_cyc / TD;
  endfunction

  task automatic model_reset();
    m_scr = 0; m_cyc = 0; m_tp = 0;
    m_sel = 0; m_eog = 0; m_clr = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit to;
    to = dur(m_scr) > 0 && (m_cyc + 1 == dur(m_scr) * TD);
    nxt = m_scr;
    m_sel = 0; m_eog = 0; m_clr = 0;
    case (m_scr)
      0: if (to) nxt = 1;
      1: if (mode_sel_valid) begin
           m_sel = 1;
           if (mode_learn) begin nxt = 2; m_tp = 0; end
           else begin nxt = 3; m_tp = mode_two_player; end
         end
      2: if (end_tutorial || to) nxt = 1;
      3: if (end_game_early || to) begin nxt = 4; m_eog = 1; end
      4: if (to) nxt = 5;
      5: if (again_yes) begin nxt = 1; m_clr = 1; end
         else if (again_no || to) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_scr) begin m_scr = nxt; m_cyc = 0; end
    else m_cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $display("FAIL %s: observed %0d expected %0d at %0t",
               tag, obs, expv, $time);
      $error("%s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int s;
    bit sn;
    s = exp_secs();
    sn = (m_scr == 3) && s <= 30 && s > 25;
    chk({tag, ".screen"}, 32'(screen), 32'(m_scr));
    chk({tag, ".flags"},
        32'({play_again, leaderboard, play_active,
             learn_active, select_mode, logo}),
        32'(1) << m_scr);
    chk({tag, ".secs"}, 32'(seconds_left), 32'(s));
    chk({tag, ".tp"}, 32'(two_player_mode), 32'(m_tp));
    chk({tag, ".sel"}, 32'(selected_a_mode), 32'(m_sel));
    chk({tag, ".eog"}, 32'(end_of_game), 32'(m_eog));
    chk({tag, ".clr"}, 32'(score_clear), 32'(m_clr));
    chk({tag, ".snitch"}, 32'(snitch_powerup), 32'(sn));
  endtask

  task automatic step(input bit msv, input bit two, input bit lrn,
                      input bit eg, input bit et, input bit ay,
                      input bit an);
    mode_sel_valid = msv; mode_two_player = two; mode_learn = lrn;
    end_game_early = eg; end_tutorial = et; again_yes = ay; again_no = an;
    @(posedge clock);
    model_step();
    #1;
    check_all("cyc");
    if (snitch_powerup) snitch_seen++;
    if (end_of_game) eog_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit rp();
    return $urandom_range(15) == 0;
  endfunction

  task automatic rstep();
    step(rp(), $urandom_range(1), $urandom_range(1),
         rp(), rp(), rp(), rp());
  endtask

  initial begin
    resetn = 1'b0;
    mode_sel_valid = 0; mode_two_player = 0; mode_learn = 0;
    end_game_early = 0; end_tutorial = 0; again_yes = 0; again_no = 0;
    repeat (2) @(negedge clock);
    model_reset();
    check_all("reset");
    resetn = 1'b1;

    idle(12);
    chk("logo_exit", 32'(screen), 32'd1);

    snitch_seen = 0;
    eog_seen = 0;
    step(1, 1, 0, 0, 0, 0, 0);
    chk("play_entry_tp", 32'(two_player_mode), 32'd1);
    chk("play_entry_secs", 32'(seconds_left), 32'd60);

    idle(239);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("early_final_screen", 32'(screen), 32'd4);
    chk("early_final_secs", 32'(seconds_left), 32'd10);
    idle(3);
    chk("snitch_cycles", 32'(snitch_seen), 32'd20);
    chk("eog_once", 32'(eog_seen), 32'd1);

    for (int i = 0; i < 37; i++) rstep();
    chk("lead_timeout", 32'(screen), 32'd5);

    step(0, 0, 0, 0, 0, 1, 1);
    chk("yes_wins", 32'(screen), 32'd1);
    chk("yes_clear", 32'(score_clear), 32'd1);

    step(1, 1, 1, 0, 0, 0, 0);
    chk("learn_screen", 32'(screen), 32'd2);
    chk("learn_tp", 32'(two_player_mode), 32'd0);
    idle(5);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("tut_exit", 32'(screen), 32'd1);

    step(1, 0, 0, 0, 0, 0, 0);
    idle(240);
    chk("play_timeout", 32'(screen), 32'd4);
    idle(40);
    idle(40);
    chk("again_timeout", 32'(screen), 32'd0);
    chk("again_timeout_secs", 32'(seconds_left), 32'd3);

    for (int i = 0; i < 3000; i++) rstep();

    // steer to PLAY, bounded
    for (int i = 0; i < 400 && m_scr != 3; i++) begin
      case (m_scr)
        1: step(1, 1, 0, 0, 0, 0, 0);
        2: step(0, 0, 0, 0, 1, 0, 0);
        5: step(0, 0, 0, 0, 0, 1, 0);
        default: idle(1);
      endcase
    end
    chk("reach_play", 32'(screen), 32'd3);
    idle(50);

    resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clock);
    resetn = 1'b1;
    idle(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
